// File: rtl/iterative_shifter.sv
// Multi-cycle shifter/rotator: one bit position per clock under start/finished handshake.
// Optional sign-filling right shift enabled by defining SHIFTER_ARITH_EN.
module iterative_shifter #(
    parameter int N = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    output logic         o_finished,
    input  logic         i_direction,
    input  logic         i_rotate,
`ifdef SHIFTER_ARITH_EN
    input  logic         i_arithmetic,
`endif
    input  logic [N-1:0] i_iterations,
    input  logic [N-1:0] i_value,
    output logic [N-1:0] o_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_value;
    logic [N-1:0] r_count;
    logic         r_dir;
    logic         r_rot;
    logic         r_finished;
    logic         w_arith;
    logic         w_fill_left;
    logic         w_fill_right;
    logic [N-1:0] w_next;

`ifdef SHIFTER_ARITH_EN
    logic r_arith;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_arith <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_arith <= i_arithmetic;
        end
    end

    assign w_arith = r_arith;
`else
    assign w_arith = 1'b0;
`endif

    // Rotate recirculates the outgoing bit; arithmetic right copies the MSB.
    always_comb begin
        w_fill_left  = r_rot & r_value[N-1];
        w_fill_right = r_rot ? r_value[0] : (w_arith & r_value[N-1]);
        if (r_dir) begin
            w_next = {w_fill_right, r_value[N-1:1]};
        end else begin
            w_next = {r_value[N-2:0], w_fill_left};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_value    <= '0;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_rot      <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_value <= i_value;
                        r_count <= i_iterations;
                        r_dir   <= i_direction;
                        r_rot   <= i_rotate;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_count != '0) begin
                        r_value <= w_next;
                        r_count <= r_count - N'(1);
                    end else begin
                        r_state    <= DONE;
                        r_finished <= 1'b1;
                    end
                end
                DONE: begin
                    if (!i_start) begin
                        r_state    <= IDLE;
                        r_finished <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_finished <= 1'b0;
                end
            endcase
        end
    end

    assign o_value    = r_value;
    assign o_finished = r_finished;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter (N=4): vector table, handshake/reset sequences,
// and random operations against an arithmetic reference model.
module tb_iterative_shifter;

    localparam int N = 4;

    logic         i_clock;
    logic         i_reset;
    logic         i_start;
    logic         o_finished;
    logic         i_direction;
    logic         i_rotate;
    logic         arith;
    logic [N-1:0] i_iterations;
    logic [N-1:0] i_value;
    logic [N-1:0] o_value;

    int checks = 0;
    int errors = 0;

    iterative_shifter #(.N(N)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .o_finished   (o_finished),
        .i_direction  (i_direction),
        .i_rotate     (i_rotate),
`ifdef SHIFTER_ARITH_EN
        .i_arithmetic (arith),
`endif
        .i_iterations (i_iterations),
        .i_value      (i_value),
        .o_value      (o_value)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [3:0] v;
        bit         d;
        bit         r;
        bit         a;
        logic [3:0] it;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, rotate by count mod N.
    function automatic logic [3:0] model(input logic [3:0] v, input bit d,
                                         input bit r, input bit a, input int it);
        int x;
        int k;
        x = int'(v);
        if (r) begin
            k = it % N;
            if (d) x = (x >> k) | (x << (N - k));
            else   x = (x << k) | (x >> (N - k));
        end else if (!d) begin
            x = x << it;
        end else if (a) begin
            x = (v[3] ? x - 16 : x) >>> it;
        end else begin
            x = x >> it;
        end
        return 4'(x);
    endfunction

    task automatic run_op(input string nm, input logic [3:0] v, input bit d,
                          input bit r, input bit a, input logic [3:0] it,
                          input logic [3:0] exp);
        int cyc;
        i_value      = v;
        i_direction  = d;
        i_rotate     = r;
        arith        = a;
        i_iterations = it;
        i_start      = 1'b1;
        @(posedge i_clock); #1;
        check({nm, "/busy"}, int'(o_finished), 0);
        i_value      = 4'($urandom);
        i_direction  = ~d;
        i_rotate     = ~r;
        arith        = ~a;
        i_iterations = 4'($urandom);
        cyc = 0;
        while (!o_finished && cyc < 40) begin
            @(posedge i_clock); #1;
            cyc++;
        end
        check({nm, "/latency"}, cyc, int'(it) + 1);
        check({nm, "/value"}, int'(o_value), int'(exp));
        i_start = 1'b0;
        @(posedge i_clock); #1;
        check({nm, "/idle_fin"}, int'(o_finished), 0);
        check({nm, "/idle_hold"}, int'(o_value), int'(exp));
    endtask

    initial begin
        bit         ar_en;
        logic [3:0] rv;
        logic [3:0] rit;
        bit         rd, rr, ra;
`ifdef SHIFTER_ARITH_EN
        ar_en = 1'b1;
`else
        ar_en = 1'b0;
`endif
        i_reset = 1'b0; i_start = 1'b0; i_direction = 1'b0;
        i_rotate = 1'b0; arith = 1'b0; i_iterations = '0; i_value = '0;

        tbl.push_back('{4'b1001, 1'b0, 1'b0, 1'b0, 4'd1,  4'b0010});
        tbl.push_back('{4'b1001, 1'b0, 1'b1, 1'b0, 4'd1,  4'b0011});
        tbl.push_back('{4'b1001, 1'b0, 1'b1, 1'b0, 4'd5,  4'b0011});
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 1'b0, 4'd2,  4'b0010});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 1'b0, 4'd2,  4'b0110});
        tbl.push_back('{4'b1011, 1'b0, 1'b0, 1'b0, 4'd0,  4'b1011});
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 1'b0, 4'd15, 4'b0000});
        tbl.push_back('{4'b1111, 1'b1, 1'b0, 1'b0, 4'd15, 4'b0000});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 1'b0, 4'd15, 4'b0011});
`ifdef SHIFTER_ARITH_EN
        tbl.push_back('{4'b1001, 1'b1, 1'b0, 1'b1, 4'd2,  4'b1110});
        tbl.push_back('{4'b1001, 1'b0, 1'b0, 1'b1, 4'd1,  4'b0010});
        tbl.push_back('{4'b1001, 1'b1, 1'b1, 1'b1, 4'd2,  4'b0110});
`endif

        #12;
        check("reset/value", int'(o_value), 0);
        check("reset/fin", int'(o_finished), 0);
        i_reset = 1'b1;
        @(posedge i_clock); #1;

        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].r,
                   tbl[i].a, tbl[i].it, tbl[i].exp);

        // Start held high through DONE: one operation only.
        i_value = 4'b0110; i_direction = 1'b0; i_rotate = 1'b0;
        arith = 1'b0; i_iterations = 4'd1; i_start = 1'b1;
        repeat (3) @(posedge i_clock);
        #1;
        check("held/fin", int'(o_finished), 1);
        i_value = 4'b0001;
        repeat (2) @(posedge i_clock);
        #1;
        check("held/fin2", int'(o_finished), 1);
        check("held/value", int'(o_value), 4'b1100);
        i_start = 1'b0;
        @(posedge i_clock); #1;
        check("held/idle", int'(o_finished), 0);
        @(posedge i_clock); #1;
        check("held/idle_hold", int'(o_value), 4'b1100);
        run_op("restart", 4'b0001, 1'b0, 1'b1, 1'b0, 4'd2, 4'b0100);

        // Asynchronous reset in the middle of a long shift.
        i_value = 4'b1111; i_direction = 1'b1; i_rotate = 1'b1;
        i_iterations = 4'd12; i_start = 1'b1;
        repeat (4) @(posedge i_clock);
        #1;
        i_start = 1'b0;
        check("midrst/busy", int'(o_finished), 0);
        #2;
        i_reset = 1'b0;
        #1;
        check("midrst/value", int'(o_value), 0);
        check("midrst/fin", int'(o_finished), 0);
        @(posedge i_clock); #3;
        i_reset = 1'b1;
        repeat (20) @(posedge i_clock);
        #1;
        check("midrst/stay_idle", int'(o_finished), 0);
        check("midrst/stay_val", int'(o_value), 0);

        for (int n = 0; n < 40; n++) begin
            rv  = 4'($urandom);
            rit = 4'($urandom);
            rd  = 1'($urandom);
            rr  = 1'($urandom);
            ra  = ar_en & 1'($urandom);
            run_op($sformatf("rnd%0d", n), rv, rd, rr, ra, rit,
                   model(rv, rd, rr, ra, int'(rit)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
